// File: rtl/taxi_i2c_target_pkg.sv
// Shared types for the I2C register target: FSM states and R/W bit encoding.
// No logic; imported by the target top level.
// No flow control.
package taxi_i2c_target_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_PTR,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        IGNORE
    } state_t;

    localparam logic I2C_WRITE = 1'b0;
    localparam logic I2C_READ  = 1'b1;

endpackage

// File: rtl/taxi_i2c_glitch_filter.sv
// Pad synchronizer plus stability filter for one open-drain line.
// Latency: 2 sync flops + FILTER_LEN samples before dout follows din.
// No backpressure; shorter pulses never reach dout.
module taxi_i2c_glitch_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int CW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // cnt counts consecutive samples that disagree with dout; any agreeing sample restarts it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b11;
            cnt  <= '0;
            dout <= 1'b1;
        end else begin
            sync <= {sync[0], din};
            if (sync[1] == dout) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                dout <= sync[1];
                cnt  <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/taxi_i2c_target_regs.sv
// I2C target bridging a 7-bit device address to a byte register bus with auto-incrementing pointer.
// Latency: strobes one cycle after the filtered SCL edge; reads fetched ahead during SCL low.
// No clock stretching; reg_rd_data must be valid the cycle after reg_rd_en.
module taxi_i2c_target_regs
    import taxi_i2c_target_pkg::*;
#(
    parameter int FILTER_LEN = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [6:0] dev_addr,
    input  logic       scl_i,
    output logic       scl_o,
    output logic       scl_t,
    input  logic       sda_i,
    output logic       sda_o,
    output logic       sda_t,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wr_data,
    output logic       reg_wr_en,
    output logic       reg_rd_en,
    input  logic [7:0] reg_rd_data,
    output logic       busy,
    output logic       addressed,
    output logic       start_det,
    output logic       stop_det
);

    logic scl_f, sda_f, scl_q, sda_q;
    logic scl_rise, scl_fall, start_evt, stop_evt;

    state_t     state, state_nxt;
    logic [3:0] bit_cnt, bit_cnt_nxt;
    logic [7:0] shreg, shreg_nxt;
    logic [7:0] rx_byte;
    logic       rd_mode, rd_mode_nxt;
    logic       rd_cap;
    logic       sda_t_nxt, busy_nxt, addressed_nxt;
    logic       wr_en_nxt, rd_en_nxt;
    logic [7:0] reg_addr_nxt, reg_wr_data_nxt;

    assign scl_o = 1'b0;
    assign scl_t = 1'b1;
    assign sda_o = 1'b0;

    taxi_i2c_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (scl_i),
        .dout (scl_f)
    );

    taxi_i2c_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (sda_i),
        .dout (sda_f)
    );

    assign scl_rise  = scl_f & ~scl_q;
    assign scl_fall  = ~scl_f & scl_q;
    assign start_evt = scl_f & scl_q & sda_q & ~sda_f;
    assign stop_evt  = scl_f & scl_q & ~sda_q & sda_f;
    assign rx_byte   = {shreg[6:0], sda_f};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            rd_mode     <= 1'b0;
            rd_cap      <= 1'b0;
            scl_q       <= 1'b1;
            sda_q       <= 1'b1;
            sda_t       <= 1'b1;
            reg_addr    <= '0;
            reg_wr_data <= '0;
            reg_wr_en   <= 1'b0;
            reg_rd_en   <= 1'b0;
            busy        <= 1'b0;
            addressed   <= 1'b0;
            start_det   <= 1'b0;
            stop_det    <= 1'b0;
        end else begin
            state       <= state_nxt;
            bit_cnt     <= bit_cnt_nxt;
            shreg       <= shreg_nxt;
            rd_mode     <= rd_mode_nxt;
            rd_cap      <= reg_rd_en;
            scl_q       <= scl_f;
            sda_q       <= sda_f;
            sda_t       <= sda_t_nxt;
            reg_addr    <= reg_addr_nxt;
            reg_wr_data <= reg_wr_data_nxt;
            reg_wr_en   <= wr_en_nxt;
            reg_rd_en   <= rd_en_nxt;
            busy        <= busy_nxt;
            addressed   <= addressed_nxt;
            start_det   <= start_evt;
            stop_det    <= stop_evt;
        end
    end

    always_comb begin
        state_nxt       = state;
        bit_cnt_nxt     = bit_cnt;
        shreg_nxt       = shreg;
        rd_mode_nxt     = rd_mode;
        sda_t_nxt       = sda_t;
        reg_addr_nxt    = reg_addr;
        reg_wr_data_nxt = reg_wr_data;
        wr_en_nxt       = 1'b0;
        rd_en_nxt       = 1'b0;
        busy_nxt        = busy;
        addressed_nxt   = addressed;

        // pointer advances the cycle after the write strobe so the strobe sees the old value
        if (reg_wr_en) begin
            reg_addr_nxt = reg_addr + 8'd1;
        end
        if (rd_cap) begin
            shreg_nxt = reg_rd_data;
        end

        if (stop_evt) begin
            state_nxt     = IDLE;
            sda_t_nxt     = 1'b1;
            addressed_nxt = 1'b0;
            busy_nxt      = 1'b0;
        end else if (start_evt) begin
            state_nxt     = ADDR;
            bit_cnt_nxt   = '0;
            sda_t_nxt     = 1'b1;
            busy_nxt      = 1'b1;
            addressed_nxt = 1'b0;
        end else begin
            case (state)
                ADDR, WR_PTR, WR_DATA: begin
                    if (scl_rise) begin
                        shreg_nxt   = rx_byte;
                        bit_cnt_nxt = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            if (state == ADDR) begin
                                if (enable && rx_byte[7:1] == dev_addr) begin
                                    state_nxt   = ADDR_ACK;
                                    rd_mode_nxt = rx_byte[0];
                                    rd_en_nxt   = (rx_byte[0] == I2C_READ);
                                end else begin
                                    state_nxt = IGNORE;
                                end
                            end else if (state == WR_PTR) begin
                                reg_addr_nxt = rx_byte;
                                state_nxt    = WR_ACK;
                            end else begin
                                wr_en_nxt       = 1'b1;
                                reg_wr_data_nxt = rx_byte;
                                state_nxt       = WR_ACK;
                            end
                        end
                    end
                end
                ADDR_ACK, WR_ACK: begin
                    if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            sda_t_nxt = 1'b0;
                            if (state == ADDR_ACK) begin
                                addressed_nxt = 1'b1;
                            end
                        end else begin
                            bit_cnt_nxt = '0;
                            if (state == ADDR_ACK && rd_mode == I2C_READ) begin
                                state_nxt = RD_DATA;
                                sda_t_nxt = shreg[7];
                                shreg_nxt = {shreg[6:0], 1'b1};
                            end else begin
                                sda_t_nxt = 1'b1;
                                if (!enable) begin
                                    state_nxt = IGNORE;
                                end else if (state == ADDR_ACK) begin
                                    state_nxt = WR_PTR;
                                end else begin
                                    state_nxt = WR_DATA;
                                end
                            end
                        end
                    end else if (scl_rise) begin
                        bit_cnt_nxt = 4'd9;
                    end
                end
                RD_DATA: begin
                    if (scl_rise) begin
                        bit_cnt_nxt = bit_cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            sda_t_nxt = 1'b1;
                            state_nxt = RD_ACK;
                        end else begin
                            sda_t_nxt = shreg[7];
                            shreg_nxt = {shreg[6:0], 1'b1};
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        bit_cnt_nxt  = 4'd9;
                        reg_addr_nxt = reg_addr + 8'd1;
                        if (!sda_f && enable) begin
                            rd_en_nxt = 1'b1;
                        end else begin
                            state_nxt = IGNORE;
                        end
                    end else if (scl_fall && bit_cnt == 4'd9) begin
                        state_nxt   = RD_DATA;
                        bit_cnt_nxt = '0;
                        sda_t_nxt   = shreg[7];
                        shreg_nxt   = {shreg[6:0], 1'b1};
                    end
                end
                IDLE, IGNORE: begin
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/taxi_i2c_target_regs.md
Name: taxi_i2c_target_regs

Overview:
I2C target (responder) that answers a board-management I2C initiator on a 7-bit device address. It exposes a byte-wide register bus through an 8-bit auto-incrementing register pointer. It sits behind the open-drain tristate split (_i/_o/_t) in the FPGA top level, on the main 125 MHz clock.

Parameters:
FILTER_LEN, 4, consecutive equal samples needed before the filtered SCL/SDA change (min 2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active-low
enable  in  1  1 = respond to dev_addr; 0 = never ACK
dev_addr  in  7  target device address
scl_i  in  1  SCL from pad
scl_o  out  1  SCL drive value, constant 0
scl_t  out  1  SCL tristate, constant 1 (no clock stretching)
sda_i  in  1  SDA from pad
sda_o  out  1  SDA drive value, constant 0
sda_t  out  1  SDA tristate; 0 = pull low, 1 = release
reg_addr  out  8  register pointer
reg_wr_data  out  8  write data
reg_wr_en  out  1  one-cycle write strobe
reg_rd_en  out  1  one-cycle read strobe
reg_rd_data  in  8  read data, valid the cycle after reg_rd_en
busy  out  1  bus between START and STOP
addressed  out  1  this target is selected in the current transfer
start_det  out  1  one-cycle pulse per START or repeated START
stop_det  out  1  one-cycle pulse per STOP

Behaviour:
- Reset: sda_t=1, filtered SCL/SDA=1, reg_addr=0, all strobes 0, busy=0, addressed=0, state IDLE.
- Input path: 2-flop synchronizer, then a glitch filter. The filtered output takes the new value after FILTER_LEN consecutive equal samples. Edge detect runs on the filtered signals.
- START: filtered SDA 1→0 while SCL=1. Valid in any state → ADDR, bit count 0, sda_t=1, start_det pulse.
- STOP: filtered SDA 0→1 while SCL=1. Valid in any state → IDLE, sda_t=1, addressed=0, stop_det pulse.
- Sampling and driving: sample SDA on the SCL rising edge. Change sda_t only on the SCL falling edge.
- ADDR: shift in 8 bits, MSB first.
  - If bits[7:1]==dev_addr and enable=1: drive ACK (sda_t=0) on the falling edge after bit 8, set addressed=1. R/W=0 → WR_PTR; R/W=1 → RD_DATA.
  - Otherwise → IGNORE (no drive) until the next START or STOP.
  - General call (address 0) is not recognised specially.
- WR_PTR: first data byte loads reg_addr. ACK it → WR_DATA.
- WR_DATA: each received byte gives one reg_wr_en pulse, on the cycle after the 8th rising edge, with reg_wr_data=byte and reg_addr=current pointer. The pointer then increments (wrap 0xFF→0x00) and the byte is ACKed.
- ACK driving: sda_t=0 from the falling edge after bit 8 until the falling edge after bit 9.
- Read fetch: reg_rd_en pulses one cycle after the rising edge of address bit 8 (R/W=1). reg_rd_data is captured the next cycle into the shift register.
- RD_DATA:
  - Drive the MSB on the falling edge that ends the ACK, then one bit per falling edge. A 1 bit is sent as release (sda_t=1); a 0 bit as sda_t=0.
  - Release SDA on the falling edge after bit 8.
  - At the 9th rising edge: pointer++. If master ACK (SDA=0), issue reg_rd_en next cycle (new pointer) and continue. If NACK, go to IGNORE.
- Repeated START keeps the pointer. A write followed by a repeated-START read returns data from the written pointer.
- Register bus timing: the 1-cycle read latency is covered by the filter delay, since SCL low time far exceeds FILTER_LEN+3 clk cycles.
- busy: set on START, cleared on STOP.
- enable deasserted mid-transfer: finish the current byte; ignore the next address phase.
- Async reset mid-transfer: SDA released immediately.

Decomposition:
- Package taxi_i2c_target_pkg: state enum (IDLE, ADDR, ADDR_ACK, WR_PTR, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE), I2C R/W bit constants.
- Sub-module taxi_i2c_glitch_filter (synchronizer + FILTER_LEN stability counter), instantiated once each for SCL and SDA.

Test Plan:
1. dev_addr=0x50; write 0xA0, 0x10, 0xA5, 0x5A, STOP → ACK on every byte; reg_wr_en with (0x10,0xA5) then (0x11,0x5A); stop_det pulses once.
2. Write 0xA0, 0x20; repeated START; 0xA1; read 2 bytes ACK then NACK, with reg_rd_data = 0x3C then 0xC3 → reg_rd_en at reg_addr 0x20 and 0x21; SDA carries 0x3C, 0xC3; final reg_addr=0x22.
3. Address 0xA2 (0x51) → SDA never driven, no reg strobes, addressed=0; the next START with 0xA0 is ACKed.
4. FILTER_LEN=4, 2-cycle low glitch on SCL during a data bit → no extra bit sampled; byte received intact.
5. Pointer 0xFF, write 2 bytes → writes land at 0xFF and 0x00.
6. rst_n asserted while driving ACK → sda_t=1 asynchronously; after release, state IDLE, busy=0, reg_addr=0.
